acs_unit: RTL

Add-Compare-Select unit of the K=7, rate-1/2 (133/171 octal) Viterbi decoder in the OFDM receive chain.
- Takes one soft-bit pair per trellis step and updates 64 path metrics.
- Emits the 64-bit survivor word per step, which feeds the trace-back unit's survivor RAM.
- After every DEPTH steps, emits the minimum-metric state as the trace-back start state.

---
 rtl/acs_unit_pkg.sv | 14 +
 rtl/acs_unit_min_state_tree.sv | 58 +++++
 rtl/acs_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/acs_unit_pkg.sv
// acs_unit_pkg: shared trellis constants and the K=7 133/171 branch-label function
package acs_unit_pkg;
  localparam int DEPTH_DEF = 32;
  localparam int SOFT_W_DEF = 3;
  localparam int PM_W_DEF = 8;
  localparam int INIT_PM = 64;
  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;
  function automatic logic [1:0] enc_bits(input logic [5:0] p, input logic u);
    logic [6:0] v;
    v = {u, p[0], p[1], p[2], p[3], p[4], p[5]};
    return {^(v & G0), ^(v & G1)};
  endfunction
endpackage

// File: rtl/acs_unit_min_state_tree.sv
// min_state_tree: 3-stage pipelined 64->16->4->1 modulo-min search returning the winning state
module min_state_tree #(
  parameter int PM_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [64*PM_W-1:0]   pm,
  input  logic                 pm_vld,
  output logic [5:0]           state,
  output logic                 state_vld
);
  localparam int E = PM_W + 6;
  localparam logic [PM_W-1:0] HALF = {1'b1, {(PM_W-1){1'b0}}};
  logic [16*E-1:0] n1, s1;
  logic [4*E-1:0] n2, s2;
  logic v1, v2;
  function automatic logic better(input logic [PM_W-1:0] a, input logic [PM_W-1:0] b);
    return (b - a) >= HALF;
  endfunction
  function automatic logic [E-1:0] pick(input logic [E-1:0] a, input logic [E-1:0] b);
    return better(a[E-1:6], b[E-1:6]) ? b : a;
  endfunction
  function automatic logic [E-1:0] min4(input logic [4*E-1:0] x);
    return pick(pick(x[0+:E], x[E+:E]), pick(x[2*E+:E], x[3*E+:E]));
  endfunction
  function automatic logic [5:0] min4_idx(input logic [4*E-1:0] x);
    logic [E-1:0] l, r;
    l = pick(x[0+:E], x[E+:E]);
    r = pick(x[2*E+:E], x[3*E+:E]);
    return better(l[E-1:6], r[E-1:6]) ? r[5:0] : l[5:0];
  endfunction
  // first two reduction levels; entries are {metric, index}, lower index sits in lower slot
  always_comb begin
    n1 = '0;
    n2 = '0;
    for (int g = 0; g < 16; g++)
      n1[g*E +: E] = min4({pm[(4*g+3)*PM_W +: PM_W], 6'(4*g+3), pm[(4*g+2)*PM_W +: PM_W], 6'(4*g+2),
                           pm[(4*g+1)*PM_W +: PM_W], 6'(4*g+1), pm[(4*g)*PM_W +: PM_W], 6'(4*g)});
    for (int g = 0; g < 4; g++)
      n2[g*E +: E] = min4(s1[g*4*E +: 4*E]);
  end
  // pipeline registers; reset drops any search in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      state_vld <= 1'b0;
      state <= '0;
    end else begin
      v1 <= pm_vld;
      v2 <= v1;
      state_vld <= v2;
      if (pm_vld) s1 <= n1;
      if (v1) s2 <= n2;
      if (v2) state <= min4_idx(s2);
    end
  end
endmodule

// File: rtl/acs_unit.sv
// acs_unit: 64-state add-compare-select for the K=7 rate-1/2 Viterbi decoder with frame-end min search
module acs_unit
  import acs_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SOFT_W = SOFT_W_DEF,
  parameter int PM_W = PM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SOFT_W-1:0] di_soft_a,
  input  logic [SOFT_W-1:0] di_soft_b,
  input  logic              di_vld,
  input  logic              di_start,
  output logic [63:0]       do_sur_path,
  output logic              do_sur_path_vld,
  output logic [5:0]        do_cur_state,
  output logic              do_cur_state_vld
);
  localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [SOFT_W-1:0] SMAX = '1;
  localparam logic [PM_W-1:0] HALF = {1'b1, {(PM_W-1){1'b0}}};
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(INIT_PM);
  logic [SOFT_W-1:0] a_q, b_q;
  logic vld_q, start_q, last, last_vld;
  logic [PM_W-1:0] pm [64];
  logic [PM_W-1:0] src [64];
  logic [PM_W-1:0] nxt [64];
  logic [63:0] sur;
  logic [CW-1:0] cnt, step;
  logic [64*PM_W-1:0] pm_flat;
  // input register; a start only counts when its pair is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      start_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      vld_q <= di_vld;
      start_q <= di_vld & di_start;
      a_q <= di_soft_a;
      b_q <= di_soft_b;
    end
  end
  // a frame start replaces the stored metrics with the known-start-state profile
  always_comb begin
    for (int k = 0; k < 64; k++) src[k] = start_q ? ((k == 0) ? '0 : PM_INIT) : pm[k];
    for (int k = 0; k < 64; k++) pm_flat[k*PM_W +: PM_W] = pm[k];
  end
  assign step = start_q ? '0 : cnt;
  assign last = step == CW'(DEPTH - 1);
  for (genvar n = 0; n < 64; n++) begin : g_acs
    localparam logic [5:0] NS = 6'(n);
    localparam logic [5:0] P0 = {1'b0, NS[5:1]};
    localparam logic [5:0] P1 = {1'b1, NS[5:1]};
    logic [1:0] e0, e1;
    logic [SOFT_W:0] bm0, bm1;
    logic [PM_W-1:0] c0, c1;
    assign e0 = enc_bits(P0, NS[0]);
    assign e1 = enc_bits(P1, NS[0]);
    assign bm0 = {1'b0, e0[1] ? SMAX - a_q : a_q} + {1'b0, e0[0] ? SMAX - b_q : b_q};
    assign bm1 = {1'b0, e1[1] ? SMAX - a_q : a_q} + {1'b0, e1[0] ? SMAX - b_q : b_q};
    assign c0 = src[P0] + PM_W'(bm0);
    assign c1 = src[P1] + PM_W'(bm1);
    assign sur[n] = (c1 - c0) >= HALF;
    assign nxt[n] = sur[n] ? c1 : c0;
  end
  // metric/survivor registers and the frame step counter; everything holds across di_vld gaps
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) pm[k] <= (k == 0) ? '0 : PM_INIT;
      do_sur_path <= '0;
      do_sur_path_vld <= 1'b0;
      last_vld <= 1'b0;
      cnt <= '0;
    end else begin
      do_sur_path_vld <= vld_q;
      last_vld <= vld_q & last;
      if (vld_q) begin
        for (int k = 0; k < 64; k++) pm[k] <= nxt[k];
        do_sur_path <= sur;
        cnt <= last ? '0 : step + 1'b1;
      end
    end
  end
  min_state_tree #(.PM_W(PM_W)) u_tree (
    .clk(clk),
    .rst(rst),
    .pm(pm_flat),
    .pm_vld(last_vld),
    .state(do_cur_state),
    .state_vld(do_cur_state_vld)
  );
endmodule
